// File: rtl/pipe_test_sequencer.sv
// pipe_test_sequencer: run control for the host pipe speed test.
// Generates a counting pattern towards the host and checks the returned stream.
module pipe_test_sequencer #(
  parameter int LEN_W = 32,
  parameter int CYC_W = 32
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       mode,
  input  logic [LEN_W-1:0] length,
  output logic             f2p_wr_en,
  output logic [127:0]     f2p_din,
  input  logic             f2p_full,
  output logic             p2f_rd_en,
  input  logic [127:0]     p2f_dout,
  input  logic             p2f_empty,
  input  logic             p2f_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [LEN_W-1:0] wr_count,
  output logic [LEN_W-1:0] chk_count,
  output logic [31:0]      err_count,
  output logic [LEN_W-1:0] first_err_idx,
  output logic [CYC_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] L_ONE =
    {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] L_ALL = '1;
  localparam logic [CYC_W-1:0] C_ONE =
    {{(CYC_W-1){1'b0}}, 1'b1};
  localparam logic [CYC_W-1:0] C_ALL = '1;
  localparam logic [31:0] E_MAX = 32'hFFFF_FFFF;

  state_t           state;
  logic             gen_en_q;
  logic             chk_en_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] rd_issued;

  logic run;
  logic start_go;
  logic wr_go;
  logic rd_go;
  logic chk_go;
  logic mism;
  logic gen_fin;
  logic chk_fin;

  // Word k carries lanes 4k..4k+3, lowest value in the top lane.
  function automatic logic [127:0] pat(
    input logic [LEN_W-1:0] k
  );
    logic [31:0] b;
    b = 32'(k);
    b = {b[29:0], 2'b00};
    return {b, b | 32'd1, b | 32'd2, b | 32'd3};
  endfunction

  assign run      = (state == S_RUN);
  assign start_go = start &
                    ((state == S_IDLE) |
                     (state == S_DONE));

  assign wr_go = run & gen_en_q & ~f2p_full &
                 (wr_count < len_q);
  assign rd_go = run & chk_en_q & ~p2f_empty &
                 (rd_issued < len_q);
  assign chk_go = run & p2f_valid;
  assign mism   = (p2f_dout != pat(chk_count));

  assign gen_fin = ~gen_en_q | (wr_count == len_q);
  assign chk_fin = ~chk_en_q | (chk_count == len_q);

  assign f2p_wr_en = wr_go;
  assign p2f_rd_en = rd_go;

  // Run state machine with its registered status flags.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      gen_en_q <= 1'b0;
      chk_en_q <= 1'b0;
      len_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_RUN;
            busy     <= 1'b1;
            done     <= 1'b0;
            aborted  <= 1'b0;
            gen_en_q <= mode[0];
            chk_en_q <= mode[1];
            len_q    <= length;
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (gen_fin && chk_fin) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Generator: count writes and precompute the next pattern word.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      wr_count <= '0;
      f2p_din  <= pat('0);
    end else if (start_go) begin
      wr_count <= '0;
      f2p_din  <= pat('0);
    end else if (wr_go) begin
      wr_count <= wr_count + L_ONE;
      f2p_din  <= pat(wr_count + L_ONE);
    end
  end

  // Reads issued ahead of the data returning a cycle later.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      rd_issued <= '0;
    end else if (start_go) begin
      rd_issued <= '0;
    end else if (rd_go) begin
      rd_issued <= rd_issued + L_ONE;
    end
  end

  // Checker: compare returned words and track errors.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      chk_count     <= '0;
      err_count     <= '0;
      first_err_idx <= L_ALL;
    end else if (start_go) begin
      chk_count     <= '0;
      err_count     <= '0;
      first_err_idx <= L_ALL;
    end else if (chk_go) begin
      chk_count <= chk_count + L_ONE;
      if (mism) begin
        if (err_count != E_MAX) begin
          err_count <= err_count + 32'd1;
        end
        if (first_err_idx == L_ALL) begin
          first_err_idx <= chk_count;
        end
      end
    end
  end

  // Saturating count of cycles spent in RUN.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      cycles <= '0;
    end else if (start_go) begin
      cycles <= '0;
    end else if (run && cycles != C_ALL) begin
      cycles <= cycles + C_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_test_sequencer.sv
// tb_pipe_test_sequencer: directed runs with write scoreboard
// and a 1-cycle-latency read FIFO model.
module tb_pipe_test_sequencer;

  logic         sys_clk = 1'b0;
  logic         rstn;
  logic         start;
  logic         abort;
  logic [1:0]   mode;
  logic [31:0]  length;
  logic         f2p_wr_en;
  logic [127:0] f2p_din;
  logic         f2p_full;
  logic         p2f_rd_en;
  logic [127:0] p2f_dout;
  logic         p2f_empty;
  logic         p2f_valid;
  logic         busy;
  logic         done;
  logic         aborted;
  logic [31:0]  wr_count;
  logic [31:0]  chk_count;
  logic [31:0]  err_count;
  logic [31:0]  first_err_idx;
  logic [31:0]  cycles;

  pipe_test_sequencer #(.LEN_W(32), .CYC_W(32)) dut (
    .sys_clk       (sys_clk),
    .rstn          (rstn),
    .start         (start),
    .abort         (abort),
    .mode          (mode),
    .length        (length),
    .f2p_wr_en     (f2p_wr_en),
    .f2p_din       (f2p_din),
    .f2p_full      (f2p_full),
    .p2f_rd_en     (p2f_rd_en),
    .p2f_dout      (p2f_dout),
    .p2f_empty     (p2f_empty),
    .p2f_valid     (p2f_valid),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .wr_count      (wr_count),
    .chk_count     (chk_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .cycles        (cycles)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] src_q[$];
  logic         rd_pend = 1'b0;
  logic         full_tgl = 1'b0;
  int           n_wr = 0;
  int           n_rd = 0;
  int           n_chk = 0;
  logic [31:0]  hold_wr;
  logic [31:0]  hold_chk;

  function automatic logic [127:0] pat(int unsigned k);
    logic [31:0] b;
    b = k * 4;
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: FIFO model updates after the edge, strobes sampled later.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rd_pend && src_q.size() > 0) begin
      p2f_dout  = src_q.pop_front();
      p2f_valid = 1'b1;
    end else begin
      p2f_valid = 1'b0;
    end
    f2p_full  = full_tgl ? ~f2p_full : 1'b0;
    p2f_empty = (src_q.size() == 0);
    #1;
    if (p2f_valid && busy) n_chk++;
    rd_pend = p2f_rd_en;
    if (p2f_rd_en) n_rd++;
    if (f2p_wr_en) begin
      n_wr++;
      chk("wr_while_full", {127'b0, f2p_full}, 128'd0);
      chk("wr_expected", {127'b0, exp_q.size() > 0}, 128'd1);
      if (exp_q.size() > 0) chk("wr_data", f2p_din, exp_q.pop_front());
    end
  endtask

  task automatic run_to_done(int max_cyc);
    for (int i = 0; i < max_cyc && !done; i++) tick();
    chk("done_in_time", {127'b0, done}, 128'd1);
  endtask

  task automatic begin_run(logic [1:0] m, logic [31:0] len);
    mode   = m;
    length = len;
    n_wr   = 0;
    n_rd   = 0;
    n_chk  = 0;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("busy_after_start", {127'b0, busy}, 128'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    mode      = 2'd0;
    length    = 32'd0;
    f2p_full  = 1'b0;
    p2f_dout  = '0;
    p2f_empty = 1'b1;
    p2f_valid = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    rstn = 1'b1;
    #1;

    // Reset state
    chk("rst_busy", {127'b0, busy}, 128'd0);
    chk("rst_done", {127'b0, done}, 128'd0);
    chk("rst_aborted", {127'b0, aborted}, 128'd0);
    chk("rst_wr_en", {127'b0, f2p_wr_en}, 128'd0);
    chk("rst_rd_en", {127'b0, p2f_rd_en}, 128'd0);
    chk("rst_din", f2p_din, pat(0));
    chk("rst_first_err", 128'(first_err_idx), 128'hFFFF_FFFF);
    chk("rst_counts", 128'({wr_count, chk_count, err_count, cycles}), 128'd0);

    // Generate-only, no stalls
    for (int k = 0; k < 4; k++) exp_q.push_back(pat(k));
    begin_run(2'd1, 32'd4);
    run_to_done(20);
    chk("g1_busy", {127'b0, busy}, 128'd0);
    chk("g1_wr_count", 128'(wr_count), 128'd4);
    chk("g1_cycles", 128'(cycles), 128'd5);
    chk("g1_nwr", 128'(n_wr), 128'd4);
    chk("g1_nrd", 128'(n_rd), 128'd0);
    chk("g1_sb_empty", 128'(exp_q.size()), 128'd0);
    chk("g1_p3", pat(3), 128'h0000000C_0000000D_0000000E_0000000F);

    // Generate-only with full toggling
    full_tgl = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(pat(k));
    begin_run(2'd1, 32'd4);
    run_to_done(40);
    full_tgl = 1'b0;
    chk("g2_wr_count", 128'(wr_count), 128'd4);
    chk("g2_nwr", 128'(n_wr), 128'd4);
    chk("g2_sb_empty", 128'(exp_q.size()), 128'd0);
    tick();

    // Check-only, clean data
    for (int k = 0; k < 3; k++) src_q.push_back(pat(k));
    p2f_empty = 1'b0;
    begin_run(2'd2, 32'd3);
    run_to_done(20);
    chk("c1_chk_count", 128'(chk_count), 128'd3);
    chk("c1_err_count", 128'(err_count), 128'd0);
    chk("c1_first_err", 128'(first_err_idx), 128'hFFFF_FFFF);
    chk("c1_nrd", 128'(n_rd), 128'd3);
    chk("c1_nwr", 128'(n_wr), 128'd0);
    tick();

    // Check-only, word 1 corrupted
    src_q.push_back(pat(0));
    src_q.push_back(pat(1) ^ 128'd1);
    src_q.push_back(pat(2));
    p2f_empty = 1'b0;
    begin_run(2'd2, 32'd3);
    run_to_done(20);
    chk("c2_err_count", 128'(err_count), 128'd1);
    chk("c2_first_err", 128'(first_err_idx), 128'd1);
    chk("c2_chk_count", 128'(chk_count), 128'd3);
    chk("c2_done", {127'b0, done}, 128'd1);
    tick();

    // Both directions, aborted at cycle 20
    for (int k = 0; k < 1000; k++) begin
      exp_q.push_back(pat(k));
      src_q.push_back(pat(k));
    end
    p2f_empty = 1'b0;
    begin_run(2'd3, 32'd1000);
    repeat (19) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", {127'b0, busy}, 128'd0);
    chk("ab_done", {127'b0, done}, 128'd0);
    chk("ab_aborted", {127'b0, aborted}, 128'd1);
    chk("ab_wr_count", 128'(wr_count), 128'(n_wr));
    chk("ab_chk_count", 128'(chk_count), 128'(n_chk));
    chk("ab_cycles", 128'(cycles), 128'd20);
    hold_wr  = wr_count;
    hold_chk = chk_count;
    repeat (4) tick();
    chk("ab_hold_wr", 128'(wr_count), 128'(hold_wr));
    chk("ab_hold_chk", 128'(chk_count), 128'(hold_chk));
    chk("ab_hold_busy", {127'b0, busy}, 128'd0);

    // Rerun to completion; start mid-run is ignored
    exp_q.delete();
    src_q.delete();
    for (int k = 0; k < 1000; k++) begin
      exp_q.push_back(pat(k));
      src_q.push_back(pat(k));
    end
    p2f_empty = 1'b0;
    begin_run(2'd3, 32'd1000);
    chk("rr_aborted_clr", {127'b0, aborted}, 128'd0);
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(3000);
    chk("rr_wr_count", 128'(wr_count), 128'd1000);
    chk("rr_chk_count", 128'(chk_count), 128'd1000);
    chk("rr_err_count", 128'(err_count), 128'd0);
    chk("rr_cycles", 128'(cycles), 128'd1002);
    chk("rr_nwr", 128'(n_wr), 128'd1000);
    chk("rr_sb_empty", 128'(exp_q.size()), 128'd0);
    chk("rr_aborted", {127'b0, aborted}, 128'd0);
    tick();

    // Zero length: one RUN cycle, no strobes, start while busy ignored
    begin_run(2'd3, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("z_done", {127'b0, done}, 128'd1);
    chk("z_busy", {127'b0, busy}, 128'd0);
    chk("z_cycles", 128'(cycles), 128'd1);
    chk("z_strobes", 128'(n_wr + n_rd), 128'd0);
    tick();

    // Reset in mid-run clears outputs at once
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(pat(k));
      src_q.push_back(pat(k));
    end
    p2f_empty = 1'b0;
    begin_run(2'd3, 32'd8);
    repeat (3) tick();
    #1;
    rstn = 1'b0;
    #1;
    chk("mr_busy", {127'b0, busy}, 128'd0);
    chk("mr_wr_en", {127'b0, f2p_wr_en}, 128'd0);
    chk("mr_din", f2p_din, pat(0));
    chk("mr_counts", 128'({wr_count, chk_count, cycles}), 128'd0);
    chk("mr_first_err", 128'(first_err_idx), 128'hFFFF_FFFF);
    @(posedge sys_clk);
    #1;
    rstn = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_test_sequencer.md
# pipe_test_sequencer

Run controller for the host pipe speed-test datapath, in the `sys_clk` domain between the two width-converting FIFOs. It generates a 128-bit counting pattern into the FPGA-to-PC FIFO and checks the PC-to-FPGA FIFO output against the same pattern. Each run has a programmable length, and the block reports word counts, errors and elapsed cycles. Host wire/trigger endpoints drive `start`, `abort`, `mode` and `length` and read back status.

## Interface
Parameters:
- `LEN_W`, 32: width of `length` and of the word counters.
- `CYC_W`, 32: width of the run cycle counter.

Ports:
- `sys_clk`  in  1  sole clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- `abort`  in  1  one-cycle pulse; ends a run from RUN.
- `mode`  in  2  bit0 = generate enable, bit1 = check enable. Sampled at start.
- `length`  in  LEN_W  number of 128-bit words per direction. Sampled at start.
- `f2p_wr_en`  out  1  write strobe to the FPGA-to-PC FIFO.
- `f2p_din`  out  128  pattern word to the FPGA-to-PC FIFO.
- `f2p_full`  in  1  full flag of the FPGA-to-PC FIFO.
- `p2f_rd_en`  out  1  read strobe to the PC-to-FPGA FIFO.
- `p2f_dout`  in  128  read data from the PC-to-FPGA FIFO.
- `p2f_empty`  in  1  empty flag of the PC-to-FPGA FIFO.
- `p2f_valid`  in  1  marks `p2f_dout` valid; standard FIFO, 1-cycle read latency.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `aborted`  out  1  last run ended by `abort`.
- `wr_count`  out  LEN_W  words written in this run.
- `chk_count`  out  LEN_W  words checked in this run.
- `err_count`  out  32  mismatching words; saturates at 0xFFFFFFFF.
- `first_err_idx`  out  LEN_W  index of the first mismatching word; all-ones if there is none.
- `cycles`  out  CYC_W  sys_clk cycles spent in RUN; saturating.

## Operation
- Pattern word k: P(k) = {32'(4k), 32'(4k+1), 32'(4k+2), 32'(4k+3)}.
  - Bits [127:96] hold the lowest value, which is the first 32-bit word on the host side.
  - Arithmetic is modulo 2^32 per lane.
- State IDLE, on `start`:
  - Latch `mode` and `length`.
  - Clear `wr_count`, `chk_count`, `err_count`, `cycles` and `aborted`; set `first_err_idx` to all-ones; set `f2p_din` to P(0).
  - Next state is RUN.
- State RUN:
  - `f2p_wr_en` = gen_en & !`f2p_full` & (`wr_count` < length), combinational.
  - On each write, `wr_count` increments and `f2p_din` advances to P(`wr_count`+1).
  - `p2f_rd_en` = chk_en & !`p2f_empty` & (rd_issued < length), combinational. rd_issued is an internal counter that increments on each read.
  - On `p2f_valid`, compare `p2f_dout` with P(`chk_count`) and increment `chk_count`. On mismatch, increment `err_count`; if `first_err_idx` is still all-ones, set it to `chk_count`.
  - `cycles` increments every RUN cycle.
- RUN exits to DONE when both conditions hold:
  - generation is disabled or `wr_count` == length;
  - checking is disabled or `chk_count` == length.
- Leaving RUN for IDLE:
  - `abort` in RUN → IDLE with `aborted`=1; counters are held.
  - `abort` has priority over completion in the same cycle.
- State DONE: holds all status. `start` behaves as it does in IDLE.
- Ignored inputs:
  - `start` during RUN is ignored.
  - `abort` outside RUN is ignored.
  - `mode` = 0 or `length` = 0 gives RUN for exactly one cycle, then DONE.
- The two directions run independently. A full or empty flag stalls only its own direction, with no data loss or duplication.

## Timing
- Reset (async assert, sync deassert in the upstream reset logic):
  - State IDLE; all strobes, `busy`, `done` and `aborted` are 0; all counters are 0.
  - `f2p_din` = P(0); `first_err_idx` = all-ones.
- `start` sampled at edge t → `busy`=1 from t+1. The first `f2p_wr_en` or `p2f_rd_en` can occur in the cycle after edge t.
- The completion condition becomes true at edge t → `done`=1 and `busy`=0 from t+1.
- Read data: `p2f_rd_en` at edge t yields `p2f_valid` at edge t+1. The check counters update at edge t+1.
- With both FIFOs never stalling, a generate-only run of length N spends N+1 cycles in RUN. `cycles` reads N+1.
- A reset in mid-run immediately forces all outputs to their reset values.

## Test plan
- Reset, then mode=1, length=4, `f2p_full`=0 → four writes carrying P(0)..P(3); P(3) = {0xC,0xD,0xE,0xF}. Then `done`=1, `wr_count`=4, `cycles`=5.
- Same run with `f2p_full` toggling every other cycle → no write while full, exactly 4 writes, din sequence unbroken.
- mode=2, length=3, FIFO model returns P(0),P(1),P(2) → `chk_count`=3, `err_count`=0, `first_err_idx`=0xFFFFFFFF.
- mode=2, length=3, word 1 returned with bit 0 flipped → `err_count`=1, `first_err_idx`=1, `done`=1.
- mode=3, length=1000, with `abort` at cycle 20 → IDLE, `aborted`=1, `done`=0, counts frozen. A following `start` clears them and reruns to completion.
- length=0 with mode=3 → `busy` for 1 cycle, then `done`, no strobes. `start` asserted while busy → no effect.
